uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters, with watchdog and inter-frame gap.
// Latency: request sampled at edge k launches (tx_start/ack/tx_data) in cycle k+1; done/err one cycle after tx_done/timeout.
// Backpressure: requesters hold req and data until ack; requests are not sampled while a frame or gap is in progress.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 521,
  parameter int GAP_BITS     = 1,
  parameter int TIMEOUT_CLKS = 6252,
  parameter int CNT_W        = 16
) (
  input  logic               tx_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;

  // Terminal counts: the counter starts at 0 on entry to each state.
  localparam logic [CNT_W-1:0] TO_TC  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;

  logic             win_vld;
  logic [PTR_W-1:0] win_idx;

  // Modulo-N_REQ addition for pointer rotation.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Pick the first active requester scanning upward from the round-robin pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[wrap_idx(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = wrap_idx(ptr_q, i);
      end
    end
  end

  // Next-state logic; ack/done/err/tx_start are single-cycle pulses by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d        = S_WAIT;
          cnt_d          = '0;
          gnt_d          = win_idx;
          data_d         = req_data[8*int'(win_idx) +: 8];
          start_d        = 1'b1;
          ack_d[win_idx] = 1'b1;
        end
      end
      S_WAIT: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (tx_done || (cnt_q == TO_TC)) begin
          if (tx_done) done_d[gnt_q] = 1'b1;
          else         err_d         = 1'b1;
          ptr_d   = wrap_idx(gnt_q, 1);
          cnt_d   = '0;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_TC) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset; an aborted grant leaves no trace.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, GAP_BITS=1, TIMEOUT_CLKS=48.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The transmitter is modelled by hand-placed tx_done pulses.
module tb_uart_tx_arbiter;

  logic        tx_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .N_REQ(4), .CLKS_PER_BIT(4), .GAP_BITS(1), .TIMEOUT_CLKS(48), .CNT_W(16)
  ) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .err(err), .busy(busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  // Ticks until tx_start is seen; n = ticks taken, or -1 if the limit expired.
  task automatic wait_launch(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done got %b want 0000", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", tx_start); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", tx_data); end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_noreq got start=%b busy=%b want 0/0", tx_start, busy); end
  endtask

  task automatic test_single();
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    tick();
    n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start got %b want 1", tx_start); end
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack got %b want 0100", ack); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", tx_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    req = 4'b0000;
    repeat (39) tick();
    n_checks++; if (tx_start !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL single_wait_pulses got start=%b ack=%b want 0/0000", tx_start, ack); end
    n_checks++; if (tx_data !== 8'hA5 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_hold got data=%h busy=%b want a5/1", tx_data, busy); end
    pulse_done();
    n_checks++; if (done !== 4'b0100 || err !== 1'b0) begin n_fail++; $display("FAIL single_done got done=%b err=%b want 0100/0", done, err); end
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_gap_busy got %b want 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_gap_end got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [3:0] exp_a;
    int n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_a = 4'b0001 << (f % 4);
      wait_launch(8, n);
      n_checks++; if (n !== ((f == 0) ? 1 : 5)) begin n_fail++; $display("FAIL rr_spacing frame %0d got %0d ticks want %0d", f, n, (f == 0) ? 1 : 5); end
      n_checks++; if (tx_data !== exp_b[f]) begin n_fail++; $display("FAIL rr_data frame %0d got %h want %h", f, tx_data, exp_b[f]); end
      n_checks++; if (ack !== exp_a) begin n_fail++; $display("FAIL rr_ack frame %0d got %b want %b", f, ack, exp_a); end
      repeat (5) tick();
      pulse_done();
      n_checks++; if (done !== exp_a) begin n_fail++; $display("FAIL rr_done frame %0d got %b want %b", f, done, exp_a); end
    end
    req = 4'b0000;
    repeat (4) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_wrap();
    int n;
    req = 4'b1000;
    wait_launch(2, n);
    n_checks++; if (n !== 1 || ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got n=%0d ack=%b want 1/1000", n, ack); end
    req = 4'b1001;
    repeat (3) tick();
    pulse_done();
    n_checks++; if (done !== 4'b1000) begin n_fail++; $display("FAIL wrap_done3 got %b want 1000", done); end
    wait_launch(8, n);
    n_checks++; if (ack !== 4'b0001 || tx_data !== 8'h11) begin n_fail++; $display("FAIL wrap_to_0 got ack=%b data=%h want 0001/11", ack, tx_data); end
    repeat (3) tick();
    pulse_done();
    wait_launch(8, n);
    n_checks++; if (ack !== 4'b1000 || tx_data !== 8'h44) begin n_fail++; $display("FAIL wrap_back_3 got ack=%b data=%h want 1000/44", ack, tx_data); end
    req = 4'b0000;
    repeat (3) tick();
    pulse_done();
    repeat (4) tick();
  endtask

  task automatic test_watchdog();
    int n;
    logic saw_done;
    req = 4'b0010;
    wait_launch(2, n);
    n_checks++; if (n !== 1 || ack !== 4'b0010) begin n_fail++; $display("FAIL wd_launch got n=%0d ack=%b want 1/0010", n, ack); end
    req = 4'b0000;
    n = -1;
    saw_done = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done !== 4'b0000) saw_done = 1'b1;
      if (err === 1'b1) begin
        n = i;
        break;
      end
    end
    n_checks++; if (n !== 48) begin n_fail++; $display("FAIL wd_err_latency got %0d want 48", n); end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL wd_no_done got saw_done=%b want 0", saw_done); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wd_busy_gap got %b want 1", busy); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wd_err_pulse got %b want 0", err); end
    repeat (2) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wd_gap_busy got %b want 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_gap_end got %b want 0", busy); end
    req = 4'b1111;
    wait_launch(2, n);
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL wd_ptr_adv got ack=%b want 0100", ack); end
    req = 4'b0000;
    repeat (3) tick();
    pulse_done();
    repeat (4) tick();
  endtask

  task automatic test_simultaneous();
    int n;
    req = 4'b0001;
    wait_launch(2, n);
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL sim_launch got ack=%b want 0001", ack); end
    req = 4'b0000;
    repeat (47) tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sim_pre_err got %b want 0", err); end
    pulse_done();
    n_checks++; if (done !== 4'b0001 || err !== 1'b0) begin n_fail++; $display("FAIL sim_done_wins got done=%b err=%b want 0001/0", done, err); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sim_late_err got %b want 0", err); end
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_idle got busy=%b want 0", busy); end
    req = 4'b0100;
    @(negedge tx_clk);
    req = 4'b0000;
    tick();
    n_checks++; if (ack !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sim_withdraw got ack=%b start=%b busy=%b want 0000/0/0", ack, tx_start, busy); end
    tick();
  endtask

  task automatic test_reset_midframe();
    int n;
    logic saw;
    req_data = 32'h4433_2211;
    req = 4'b0100;
    wait_launch(2, n);
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_launch got ack=%b want 0100", ack); end
    req = 4'b0000;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ctrl got busy=%b start=%b ack=%b want 0/0/0000", busy, tx_start, ack); end
    n_checks++; if (done !== 4'b0000 || err !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_out got done=%b err=%b data=%h want 0000/0/00", done, err, tx_data); end
    rst_n = 1'b1;
    saw = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    if (done !== 4'b0000 || err !== 1'b0) saw = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done !== 4'b0000 || err !== 1'b0) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet got pulse=%b busy=%b want 0/0", saw, busy); end
    req = 4'b1111;
    wait_launch(2, n);
    n_checks++; if (ack !== 4'b0001 || tx_data !== 8'h11) begin n_fail++; $display("FAIL rst_mid_ptr got ack=%b data=%h want 0001/11", ack, tx_data); end
    req = 4'b0000;
    repeat (3) tick();
    pulse_done();
    repeat (4) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_done  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_watchdog();
    test_simultaneous();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion want finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
